// File: rtl/ha_drv_mon_pkg.sv
// ha_verif_pkg: shared types and reference model for the half-adder
// driver/monitor.
//   state_t  - run-control FSM states (IDLE/RUN/DRAIN/DONE)
//   NUM_COMB - number of distinct {a,b} input combinations
//   ha_ref   - golden half-adder response packed as {carry,sum}
package ha_verif_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_COMB = 4;

    function automatic logic [1:0] ha_ref(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/ha_drv_mon_if.sv
// ha_drv_mon_if: stimulus/response bus between the driver/monitor and the
// half adder under test.
//   a_o, b_o         - stimulus towards the adder inputs
//   sum_i, carry_i   - adder response back to the monitor
//   master modport   - driver/monitor side
//   slave modport    - adder side
interface ha_drv_mon_if;
    logic a_o;
    logic b_o;
    logic sum_i;
    logic carry_i;

    modport master (output a_o, output b_o, input sum_i, input carry_i);
    modport slave  (input a_o, input b_o, output sum_i, output carry_i);
endinterface

// File: rtl/ha_drv_mon_exp_pipe.sv
// ha_exp_pipe: LAT-deep delay line carrying {valid,carry,sum} expectations
// so that each prediction lines up with the adder's delayed response.
//   clk, rstn  - clock, asynchronous active-low clear
//   clr        - synchronous clear (new run accepted)
//   in_valid   - an expectation is entered this cycle
//   in_exp     - expected {carry,sum}
//   out_valid  - expectation at the end of the line is live
//   out_exp    - expected {carry,sum} at the end of the line
module ha_exp_pipe #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [1:0] in_exp,
    output logic       out_valid,
    output logic [1:0] out_exp
);

    logic [2:0] stage_r [LAT];

    // Shift register of expectations; cleared on reset or at a new run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                stage_r[i] <= 3'b000;
            end
        end else if (clr) begin
            for (int i = 0; i < LAT; i++) begin
                stage_r[i] <= 3'b000;
            end
        end else begin
            stage_r[0] <= {in_valid, in_exp};
            for (int i = 1; i < LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign {out_valid, out_exp} = stage_r[LAT-1];

endmodule

// File: rtl/ha_drv_mon.sv
// ha_drv_mon: sweeps all half-adder input combinations NPASS times, predicts
// each response, compares it after LAT cycles and reports the outcome.
//   clk, rstn - clock, asynchronous active-low reset
//   start     - request a run (accepted in IDLE or DONE only)
//   bus       - stimulus out (a_o/b_o), response in (sum_i/carry_i)
//   busy      - run in progress (RUN or DRAIN)
//   done      - run finished, results held
//   pass      - done with zero mismatches
//   err_cnt   - saturating mismatch count
//   vec_idx   - index of the vector currently driven
module ha_drv_mon
    import ha_verif_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int NPASS = 4,
    parameter int ERRW  = 8,
    localparam int NVEC = NUM_COMB * NPASS,
    localparam int IDXW = $clog2(NVEC)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    ha_drv_mon_if.master        bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRW-1:0]     err_cnt,
    output logic [IDXW-1:0]     vec_idx
);

    localparam int DCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NVEC - 1);
    localparam logic [DCW-1:0]  LAST_DRN  = DCW'(LAT - 1);
    localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

    state_t          state_r, state_s;
    logic [IDXW-1:0] vec_idx_r, vec_idx_s;
    logic [DCW-1:0]  drain_r, drain_s;
    logic [ERRW-1:0] err_r, err_s;
    logic            a_r, b_r, a_s, b_s;
    logic            busy_r, done_r, pass_r;
    logic            start_acc_s;
    logic            mismatch_s;
    logic            exp_valid_s;
    logic [1:0]      exp_val_s;
    logic [IDXW-1:0] idx_inc_s;

    // Expectation for the vector on the bus this cycle enters the delay line
    // at the next edge, matching the adder's own registered sampling.
    ha_exp_pipe #(.LAT(LAT)) u_exp_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (start_acc_s),
        .in_valid  (state_r == RUN),
        .in_exp    (ha_ref(a_r, b_r)),
        .out_valid (exp_valid_s),
        .out_exp   (exp_val_s)
    );

    assign idx_inc_s  = vec_idx_r + 1'b1;
    assign mismatch_s = exp_valid_s && ({bus.carry_i, bus.sum_i} != exp_val_s);

    // Next-state, vector sequencing and drain counting.
    always_comb begin
        state_s     = state_r;
        vec_idx_s   = vec_idx_r;
        drain_s     = drain_r;
        a_s         = 1'b0;
        b_s         = 1'b0;
        start_acc_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_s     = RUN;
                    vec_idx_s   = {IDXW{1'b0}};
                end else begin
                    state_s     = state_r;
                end
            end
            RUN: begin
                if (vec_idx_r == LAST_IDX) begin
                    state_s = DRAIN;
                    drain_s = {DCW{1'b0}};
                end else begin
                    vec_idx_s  = idx_inc_s;
                    {a_s, b_s} = idx_inc_s[1:0];
                end
            end
            DRAIN: begin
                if (drain_r == LAST_DRN) begin
                    state_s = DONE;
                end else begin
                    drain_s = drain_r + 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Saturating mismatch counter, cleared when a run is accepted.
    always_comb begin
        err_s = err_r;
        if (start_acc_s) begin
            err_s = {ERRW{1'b0}};
        end else if (mismatch_s && (err_r != ERR_MAX)) begin
            err_s = err_r + 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers; status flags follow the next state so
    // they are aligned with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            vec_idx_r <= {IDXW{1'b0}};
            drain_r   <= {DCW{1'b0}};
            err_r     <= {ERRW{1'b0}};
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            vec_idx_r <= vec_idx_s;
            drain_r   <= drain_s;
            err_r     <= err_s;
            a_r       <= a_s;
            b_r       <= b_s;
            busy_r    <= (state_s == RUN) || (state_s == DRAIN);
            done_r    <= (state_s == DONE);
            pass_r    <= (state_s == DONE) && (err_s == {ERRW{1'b0}});
        end
    end

    assign bus.a_o = a_r;
    assign bus.b_o = b_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign pass    = pass_r;
    assign err_cnt = err_r;
    assign vec_idx = vec_idx_r;

endmodule
